// File: rtl/bga_arb_pkg.sv
// rtl/bga_arb_pkg.sv - shared types for the bank-group round-robin arbiter
package bga_arb_pkg;

    localparam int STATE_W = 1;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational rotate / priority-encode / un-rotate picker
module rr_priority_picker #(
    parameter int NUM_BANKS = 4,
    parameter int IDX_W     = $clog2(NUM_BANKS)
) (
    input  logic [NUM_BANKS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_BANKS-1:0] winner_oh,
    output logic [IDX_W-1:0]     winner_idx,
    output logic                 any
);

    logic [NUM_BANKS-1:0] rotated;
    int                   offset;
    logic                 found;

    always_comb begin
        rotated = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            rotated[i] = req[(int'(ptr) + i) % NUM_BANKS];
        end

        // Lowest rotated position is the bank closest to ptr going upward.
        offset = 0;
        found  = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!found && rotated[i]) begin
                found  = 1'b1;
                offset = i;
            end
        end

        winner_idx = IDX_W'((int'(ptr) + offset) % NUM_BANKS);
        winner_oh  = found ? (NUM_BANKS'(1) << winner_idx) : '0;
        any        = found;
    end

endmodule

// File: rtl/bank_group_rr_arbiter.sv
// rtl/bank_group_rr_arbiter.sv - round-robin burst drain arbiter across bank queues
module bank_group_rr_arbiter
    import bga_arb_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int IDX_W     = $clog2(NUM_BANKS),
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_BANKS-1:0] req,
    input  logic [NUM_BANKS-1:0] valid,
    output logic [NUM_BANKS-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 en,
    output logic                 done,
    output logic                 busy
);

    arb_state_t           state, state_nxt;
    logic [IDX_W-1:0]     cur, cur_nxt;
    logic [IDX_W-1:0]     ptr, ptr_nxt;
    logic [IDX_W-1:0]     cur_inc;
    logic [IDX_W-1:0]     pick_ptr;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [NUM_BANKS-1:0] grant_q, grant_nxt;
    logic                 done_q, done_nxt;
    logic [NUM_BANKS-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 last_beat;
    logic                 burst_end;

    assign cur_inc   = (cur == IDX_W'(NUM_BANKS - 1)) ? '0 : cur + 1'b1;
    assign busy      = (state == DRAIN);
    assign idx       = cur;
    assign en        = start & busy & req[cur] & valid[cur];
    assign last_beat = (cnt == CNT_W'(MAX_BURST - 1));
    assign burst_end = start & busy & (~en | last_beat);
    assign grant     = grant_q;
    assign done      = done_q;

    // While draining, re-arbitration starts just past cur so cur ranks last.
    assign pick_ptr = busy ? cur_inc : ptr;

    rr_priority_picker #(
        .NUM_BANKS (NUM_BANKS),
        .IDX_W     (IDX_W)
    ) u_picker (
        .req        (req),
        .ptr        (pick_ptr),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        grant_nxt = '0;
        done_nxt  = 1'b0;
        if (start) begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        cur_nxt   = pick_idx;
                        grant_nxt = pick_oh;
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (burst_end) begin
                        done_nxt = 1'b1;
                        cnt_nxt  = '0;
                        ptr_nxt  = cur_inc;
                        if (pick_any) begin
                            cur_nxt   = pick_idx;
                            grant_nxt = pick_oh;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else if (en) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            grant_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur     <= cur_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            grant_q <= grant_nxt;
            done_q  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bank_group_rr_arbiter.sv
// tb/tb_bank_group_rr_arbiter.sv - directed self-checking bench for bank_group_rr_arbiter
module tb_bank_group_rr_arbiter;

    localparam int NB = 4;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NB-1:0] req;
    logic [NB-1:0] valid;
    logic [NB-1:0] grant;
    logic [1:0]    idx;
    logic          en;
    logic          done;
    logic          busy;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bank_group_rr_arbiter #(
        .NUM_BANKS (NB),
        .MAX_BURST (MB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .req   (req),
        .valid (valid),
        .grant (grant),
        .idx   (idx),
        .en    (en),
        .done  (done),
        .busy  (busy)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [NB-1:0] g, input logic [1:0] i,
                           input logic e, input logic d, input logic b);
        #1;
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".idx"},   32'(idx),   32'(i));
        chk({tag, ".en"},    32'(en),    32'(e));
        chk({tag, ".done"},  32'(done),  32'(d));
        chk({tag, ".busy"},  32'(busy),  32'(b));
    endtask

    initial begin
        logic [1:0] bank;

        // Reset state
        rst_n = 1'b0; start = 1'b0; req = '0; valid = '0;
        tick(); tick();
        chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        // 1: single bank, 5 beats
        rst_n = 1'b1; start = 1'b1; req = 4'b0100; valid = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_all("t1.beat", (k == 1) ? 4'b0100 : 4'b0000, 2'd2, 1'b1, 1'b0, 1'b1);
        end
        tick();
        req = '0; valid = '0;
        chk_all("t1.dry", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("t1.done", 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("t1.after", 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0);

        // 2: burst cap then back-to-back re-grant of the same bank
        req = 4'b0001; valid = 4'b0001;
        for (int k = 0; k < MB; k++) begin
            tick();
            chk_all("t2.beat", (k == 0) ? 4'b0001 : 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1);
        end
        tick();
        chk_all("t2.regrant", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1);
        req = '0; valid = '0;
        tick();
        chk_all("t2.end", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);

        // 3: fairness with all banks requesting, from a fresh pointer
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b1111; valid = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            bank = 2'(b % NB);
            for (int k = 0; k < MB; k++) begin
                tick();
                chk_all("t3.rr", (k == 0) ? (4'b0001 << bank) : 4'b0000, bank,
                        1'b1, (k == 0 && b > 0), 1'b1);
            end
        end

        // 4: freeze at cnt=7 during the bank 1 burst
        for (int k = 0; k < 7; k++) begin
            tick();
            chk_all("t4.pre", (k == 0) ? 4'b0010 : 4'b0000, 2'd1, 1'b1, (k == 0), 1'b1);
        end
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_all("t4.frozen", 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1);
            tick();
        end
        start = 1'b1;
        for (int k = 0; k < 9; k++) begin
            chk_all("t4.resume", 4'b0000, 2'd1, 1'b1, 1'b0, 1'b1);
            tick();
        end
        chk_all("t4.next", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b1);

        // 5: reset at cnt=5 of the bank 2 burst
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        tick();
        chk_all("t5.reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_all("t5.rearb", 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);

        // 6: zero-beat bursts when req is held with valid low
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req = 4'b0010; valid = 4'b0000;
        tick();
        chk_all("t6.grant", 4'b0010, 2'd1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_all("t6.regrant", 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1);
        req = '0;
        tick();
        chk_all("t6.end", 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bank_group_rr_arbiter.md
Name: bank_group_rr_arbiter

Overview:
Parametrised round-robin arbiter that selects one of NUM_BANKS bank queues inside a bank group and drains it as a burst toward the scheduler.
- Drain stops when the bank runs dry or after MAX_BURST beats, whichever comes first, so no bank starves the others.
- Sits between the per-bank request queues and the bank-group-level command mux.
- Drives the queue-select index, the per-beat enable, a grant pulse at burst start and a done pulse at burst end.

Parameters:
NUM_BANKS, 4, number of bank queues arbitrated (>=2)
IDX_W, $clog2(NUM_BANKS), width of idx
MAX_BURST, 16, maximum beats per burst (>=1)
CNT_W, $clog2(MAX_BURST+1), beat counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  arbiter enable; 0 freezes the FSM
req  in  NUM_BANKS  bank i has pending entries
valid  in  NUM_BANKS  bank i head entry is drainable this cycle
grant  out  NUM_BANKS  registered one-hot pulse, first cycle of a burst
idx  out  IDX_W  bank currently being drained
en  out  1  drain one entry from bank idx this cycle
done  out  1  registered 1-cycle pulse after the burst's last cycle
busy  out  1  FSM in DRAIN

Behaviour:
- Reset (rst_n=0 at posedge clk; synchronous, active-low):
  - state=IDLE; cur=0; ptr=0; cnt=0.
  - grant=0, done=0, en=0, busy=0, idx=0.
  - Reset mid-burst aborts the burst with no done pulse.
- States: IDLE, DRAIN.
- Winner selection (combinational):
  - Take the first set bit of req, scanning from ptr upward, modulo NUM_BANKS.
  - Only req is used; valid is not part of arbitration.
- IDLE:
  - With start=1 and |req: cur<=winner, state<=DRAIN, grant[winner]<=1 for the next cycle.
  - Otherwise remain in IDLE.
- en, idx and busy are combinational from registered state and the current inputs:
  - idx=cur.
  - busy=(state==DRAIN).
  - en=start & busy & req[cur] & valid[cur].
- Latency: request to first en is 1 cycle. The grant pulse and first en coincide when valid[cur]=1.
- DRAIN with start=1:
  - Beat cycle (en=1): cnt<=cnt+1.
  - Burst end occurs when en=0 (bank dry or not valid), or when en=1 and cnt==MAX_BURST-1 (last allowed beat).
- On burst end:
  - done<=1 for the next cycle; cnt<=0.
  - ptr<=(cur+1) mod NUM_BANKS.
  - Re-arbitrate in the same cycle, with the search starting at cur+1 so cur has lowest priority.
  - If any req is set: cur<=new winner, stay in DRAIN, pulse grant[new winner] next cycle. done and grant may be high together.
  - Otherwise state<=IDLE.
- start=0 in any state:
  - en=0; state, cur, ptr and cnt hold.
  - grant and done are not generated.
  - A pending grant or done pulse already registered still appears for its single cycle.
- MAX_BURST=1: every burst is exactly one beat, giving pure round-robin per entry.
- A bank whose req stays high with valid low may be re-granted. That burst ends immediately with zero beats and a done pulse.
- ptr wraps from NUM_BANKS-1 to 0.
- cnt never exceeds MAX_BURST-1.

Decomposition:
- Package bga_arb_pkg: state enum (IDLE, DRAIN) and a state-width constant.
- Sub-module rr_priority_picker, purely combinational:
  - Inputs: req vector, start pointer.
  - Outputs: one-hot winner, binary winner index, any flag.
  - Rotate, priority-encode, un-rotate.
- The top-level module holds the FSM, counter and pulse registers.

Test Plan:
1. Single bank: NUM_BANKS=4, MAX_BURST=16, req=0100 and valid=0100 held for 5 cycles, then req=0.
   - grant=0100 for 1 cycle; en high for 5 cycles with idx=2; done 1 cycle later; busy=0 afterwards.
2. Burst cap: req=0001, valid=0001 held continuously.
   - Exactly 16 en cycles, then done.
   - Re-grant of bank 0 with no IDLE gap; done and grant high in the same cycle.
3. Round-robin fairness: req=1111 and valid=1111 held continuously.
   - Grant order 0,1,2,3,0; each burst is 16 beats; no bubble between bursts.
4. Freeze: start=0 for 3 cycles mid-burst at cnt=7.
   - en=0 during the freeze; cnt resumes at 7; the burst still totals 16 beats.
5. Reset mid-burst: rst_n=0 at cnt=5.
   - All outputs 0 the next cycle; no done pulse; the next arbitration starts from bank 0.
6. Zero-beat burst: req=0010, valid=0000.
   - grant=0010, then done, with en never asserted; grant repeats while req is held.
